// File: rtl/sig_group_scan_mux_if.sv
// Bus bundle for sig_group_scan_mux: selection/mode controls, raw signal groups and displayed-group outputs.
interface sig_group_scan_mux_if #(
   parameter int GROUPS = 16,
   parameter int WIDTH  = 8,
   parameter int SEL_W  = 4
);
   logic [SEL_W-1:0]        iSel;
   logic [1:0]              iMode;
   logic [GROUPS*WIDTH-1:0] ivSignals;
   logic                    iClrSticky;
   logic [WIDTH-1:0]        ovSignals;
   logic [SEL_W-1:0]        ovGroup;
   logic                    oStrobe;
   logic [WIDTH-1:0]        ovChanged;

   modport master (
      output iSel, iMode, ivSignals, iClrSticky,
      input  ovSignals, ovGroup, oStrobe, ovChanged
   );

   modport slave (
      input  iSel, iMode, ivSignals, iClrSticky,
      output ovSignals, ovGroup, oStrobe, ovChanged
   );
endinterface

// File: rtl/sig_group_scan_mux.sv
// Registered group selector (direct / round-robin scan / freeze) over synchronised board signals.
// Optional per-bit sticky change capture is built when SIG_GROUP_STICKY_EN is defined.
module sig_group_scan_mux #(
   parameter int GROUPS   = 16,
   parameter int WIDTH    = 8,
   parameter int SEL_W    = 4,
   parameter int SCAN_DIV = 1000
) (
   input logic               iClk,
   input logic               iRst_n,
   sig_group_scan_mux_if.slave bus
);
   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {ST_DIRECT, ST_SCAN, ST_FREEZE} state_t;

   state_t                       r_state, w_state_nxt;
   logic [GROUPS-1:0][WIDTH-1:0] r_sync1, r_sync2;
   logic [CNT_W-1:0]             r_presc, w_presc_nxt;
   logic [SEL_W-1:0]             w_nxt, w_sel_clamp, w_step;
   logic [SEL_W-1:0]             r_grp;
   logic [WIDTH-1:0]             r_sig, r_chg;
   logic                         r_stb;

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= bus.ivSignals;
         r_sync2 <= r_sync1;
      end
   end

   // State remembers the previous cycle's mode, so SCAN entry is r_state != ST_SCAN.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) r_state <= ST_DIRECT;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = ST_DIRECT;
      case (bus.iMode)
         2'd1:    w_state_nxt = ST_SCAN;
         2'd2:    w_state_nxt = ST_FREEZE;
         default: w_state_nxt = ST_DIRECT;
      endcase
   end

   assign w_sel_clamp = ({1'b0, bus.iSel} < (SEL_W+1)'(GROUPS)) ? bus.iSel : '0;
   assign w_step      = (r_grp == SEL_W'(GROUPS-1)) ? '0 : r_grp + SEL_W'(1);

   always_comb begin
      w_nxt       = r_grp;
      w_presc_nxt = '0;
      case (w_state_nxt)
         ST_SCAN: begin
            if (r_state != ST_SCAN)                        w_nxt = w_sel_clamp;
            else if (r_presc == CNT_W'(SCAN_DIV-1))        w_nxt = w_step;
            else                                           w_presc_nxt = r_presc + CNT_W'(1);
         end
         ST_FREEZE: w_nxt = r_grp;
         default:   w_nxt = w_sel_clamp;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_presc <= '0;
         r_grp   <= '0;
         r_stb   <= 1'b0;
         r_sig   <= '0;
      end else begin
         r_presc <= w_presc_nxt;
         r_grp   <= w_nxt;
         r_stb   <= (w_nxt != r_grp);
         if (w_state_nxt != ST_FREEZE) r_sig <= r_sync2[w_nxt];
      end
   end

`ifdef SIG_GROUP_STICKY_EN
   logic [GROUPS-1:0][WIDTH-1:0] r_sync3, r_sticky, w_set;
   logic [1:0]                   r_prime;

   // Detection waits for the prime counter so the reset-release edges of sync2 are not captured.
   assign w_set = (r_prime == 2'b11) ? (r_sync2 ^ r_sync3) : '0;

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_sync3  <= '0;
         r_prime  <= '0;
         r_sticky <= '0;
         r_chg    <= '0;
      end else begin
         r_sync3 <= r_sync2;
         if (r_prime != 2'b11) r_prime <= r_prime + 2'd1;
         r_sticky <= (bus.iClrSticky ? '0 : r_sticky) | w_set;
         if (w_state_nxt != ST_FREEZE) r_chg <= r_sticky[w_nxt];
      end
   end
`else
   logic w_unused_clr;
   assign w_unused_clr = bus.iClrSticky;
   assign r_chg        = '0;
`endif

   assign bus.ovSignals = r_sig;
   assign bus.ovGroup   = r_grp;
   assign bus.oStrobe   = r_stb;
   assign bus.ovChanged = r_chg;
endmodule

// File: doc/sig_group_scan_mux.md
# sig_group_scan_mux

Parametrised, registered successor to the 16-group byte selector used for debug and status readout. It selects one WIDTH-bit group out of GROUPS groups of asynchronous board signals, under three modes:

- direct selection by iSel;
- automatic round-robin scanning;
- freeze.

It also offers optional per-bit sticky change capture. It sits between raw platform signal buses and the debug/SMBus/LED readout logic, so consumers see synchronised, glitch-free group values together with the index of the group being shown.

## Interface
- GROUPS, 16, number of signal groups (≥2).
- WIDTH, 8, bits per group (≥1).
- SEL_W, 4, selector width; must satisfy 2^SEL_W ≥ GROUPS.
- SCAN_DIV, 1000, dwell time per group in scan mode, in iClk cycles (≥1).

Clock and reset: one clock; reset is asynchronous and active-low.
- iClk  in  1  system clock.
- iRst_n  in  1  asynchronous active-low reset.
- iSel  in  SEL_W  requested group (direct mode; scan start point).
- iMode  in  2  0=DIRECT, 1=SCAN, 2=FREEZE, 3=reserved (treated as DIRECT).
- ivSignals  in  GROUPS*WIDTH  raw signals; group g = bits [g*WIDTH+WIDTH-1 : g*WIDTH].
- iClrSticky  in  1  synchronous clear of all sticky bits.
- ovSignals  out  WIDTH  synchronised value of the displayed group.
- ovGroup  out  SEL_W  index of the displayed group.
- oStrobe  out  1  one-cycle pulse when ovGroup changes.
- ovChanged  out  WIDTH  sticky change bits of the displayed group.

## Operation
- All GROUPS*WIDTH inputs pass through a 2-flop synchroniser (sync1 → sync2). Selection is taken only from sync2.
- Next group (nxt):
  - DIRECT/reserved: nxt = iSel when iSel < GROUPS; otherwise nxt = 0.
  - SCAN: a prescaler counts 0..SCAN_DIV-1. On terminal count, nxt = ovGroup+1, wrapping GROUPS-1 → 0; otherwise nxt = ovGroup.
  - FREEZE: nxt = ovGroup.
- Each cycle, ovGroup <= nxt.
  - When not FREEZE: ovSignals <= sync2[nxt].
  - In FREEZE: ovSignals holds.
- Entering SCAN from any other mode: prescaler <= 0 and ovGroup <= clamped iSel that cycle. The first dwell is the full SCAN_DIV cycles.
- Leaving SCAN: prescaler holds at 0.
- oStrobe <= (nxt != ovGroup).
- Mode changes take effect at the edge that samples the new iMode. There are no illegal states; iMode=3 aliases DIRECT.
- Synchroniser and sticky logic keep running in FREEZE.

## Timing
- Reset value of every output and register is 0: ovSignals, ovGroup, oStrobe, ovChanged, prescaler, sync1, sync2, sticky, prime counter.
- Input latency (DIRECT): ivSignals change before edge n → ovSignals updated after edge n+2 (3 register stages).
- Selector latency: iSel change before edge n → ovGroup, ovSignals and oStrobe updated after edge n.
- Scan dwell: ovGroup is stable for exactly SCAN_DIV cycles. With SCAN_DIV=1, it advances every cycle and oStrobe stays high.
- Wrap: GROUPS-1 → 0 asserts oStrobe like any other step.
- Reset mid-scan: output returns to group 0 and the prescaler to 0 immediately (asynchronous).

## Configuration
- Macro SIG_GROUP_STICKY_EN.
- Defined:
  - Keeps GROUPS*WIDTH sticky bits. Bit b is set when sync2[b] != sync3[b], where sync3 is a one-cycle delayed copy of sync2.
  - Detection is enabled only after a 2-bit prime counter saturates (3 cycles after reset release), so reset does not produce spurious sets.
  - iClrSticky clears all bits. If a set and a clear happen in the same cycle, the set wins for that bit.
  - ovChanged <= sticky[nxt], registered with the same latency as ovSignals; it holds in FREEZE.
- Undefined: no sync3 or sticky storage is built; ovChanged is tied to 0; iClrSticky is ignored.

## Test plan
- Reset, then GROUPS=16, WIDTH=8, iMode=0, iSel=5, ivSignals[47:40]=8'hA5 → ovSignals=8'hA5 three cycles after the input change; ovGroup=5; oStrobe pulses exactly once.
- iMode=0, iSel=4'hF with GROUPS=12 → ovGroup=0, ovSignals=group 0 value.
- iMode=1, SCAN_DIV=4, iSel=14, GROUPS=16 → ovGroup sequence 14,15,0,1, each value held 4 cycles; oStrobe pulses at every step including the wrap 15→0.
- In SCAN at ovGroup=3, set iMode=2, then toggle group 3 inputs → ovSignals and ovGroup hold; with SIG_GROUP_STICKY_EN, ovChanged holds. Return to iMode=0 with iSel=3 → new data and ovChanged bits visible after 1 cycle.
- With SIG_GROUP_STICKY_EN: toggle ivSignals bit 17 once, iSel=2 → ovChanged=8'h02. Assert iClrSticky in the same cycle a new toggle of bit 17 is detected → the bit stays 1. Then a clear with no toggle → ovChanged=8'h00.
- ivSignals all ones held through reset release → no sticky bits set; assert iRst_n low during scan → all outputs 0 asynchronously.
